// File: rtl/usb_desc_ep0_streamer.sv
// EP0 descriptor streamer: resolves a GET_DESCRIPTOR request against the
// descriptor table. It then streams the ROM bytes as MAXPKT-sized IN packets,
// handles the host ACK/retry handshake, and terminates with a ZLP when needed.
// Ports:
//   CLK, RESET            clock, async active-high reset
//   i_abort               new SETUP / bus reset, drops everything
//   i_hs_mode             link runs at high speed
//   i_req_valid, i_desc_type, i_desc_index, i_wlength   decoded request
//   o_req_ok, o_req_stall one-cycle verdict; o_busy = not idle
//   i_desc_*_addr/_len    descriptor table (ROM base / length)
//   i_have_strings        string descriptors present
//   o_descrom_raddr, i_descrom_rdat   ROM read port (async read)
//   i_in_req              host IN token
//   o_tx_valid/_data/_last, i_tx_ready   packet byte stream
//   o_tx_zlp              zero-length packet request
//   i_in_ack, i_in_retry  host handshake result for the last packet
module usb_desc_ep0_streamer #(
    parameter int unsigned MAXPKT    = 64,
    parameter bit          HSSUPPORT = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_abort,
    input  logic        i_hs_mode,
    input  logic        i_req_valid,
    input  logic [7:0]  i_desc_type,
    input  logic [7:0]  i_desc_index,
    input  logic [15:0] i_wlength,
    output logic        o_req_ok,
    output logic        o_req_stall,
    output logic        o_busy,
    input  logic [9:0]  i_desc_dev_addr,
    input  logic [7:0]  i_desc_dev_len,
    input  logic [9:0]  i_desc_qual_addr,
    input  logic [7:0]  i_desc_qual_len,
    input  logic [9:0]  i_desc_fscfg_addr,
    input  logic [7:0]  i_desc_fscfg_len,
    input  logic [9:0]  i_desc_hscfg_addr,
    input  logic [7:0]  i_desc_hscfg_len,
    input  logic [9:0]  i_desc_strvendor_addr,
    input  logic [7:0]  i_desc_strvendor_len,
    input  logic [9:0]  i_desc_strproduct_addr,
    input  logic [7:0]  i_desc_strproduct_len,
    input  logic [9:0]  i_desc_strserial_addr,
    input  logic [7:0]  i_desc_strserial_len,
    input  logic [9:0]  i_desc_strlang_addr,
    input  logic        i_have_strings,
    output logic [9:0]  o_descrom_raddr,
    input  logic [7:0]  i_descrom_rdat,
    input  logic        i_in_req,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_last,
    input  logic        i_tx_ready,
    output logic        o_tx_zlp,
    input  logic        i_in_ack,
    input  logic        i_in_retry
);

    localparam int unsigned AW = 10;
    localparam int unsigned LW = 8;
    localparam int unsigned XW = 16;

    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_IN, SEND, WAIT_HS, DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      type_q, type_d, index_q, index_d;
    logic [XW-1:0]   wlen_q, wlen_d, xfer_q, xfer_d, offset_q, offset_d;
    logic [AW-1:0]   base_q, base_d, raddr_q, raddr_d;
    logic [LW-1:0]   pkt_len_q, pkt_len_d, cnt_q, cnt_d;
    logic            zlp_pend_q, zlp_pend_d, patch_q, patch_d;
    logic            req_ok_q, req_ok_d, req_stall_q, req_stall_d;
    logic            tx_valid_q, tx_valid_d, tx_zlp_q, tx_zlp_d;

    logic            lk_valid, lk_patch, lk_zlp;
    logic [AW-1:0]   lk_base;
    logic [LW-1:0]   lk_len;
    logic [XW-1:0]   lk_len16, lk_xfer, remaining, off_next;
    logic            last_byte;

    // Descriptor table lookup on the latched request
    always_comb begin
        lk_valid = 1'b0;
        lk_patch = 1'b0;
        lk_base  = '0;
        lk_len   = '0;
        case (type_q)
            8'd1: begin
                lk_valid = 1'b1;
                lk_base  = i_desc_dev_addr;
                lk_len   = i_desc_dev_len;
            end
            8'd6: if (HSSUPPORT) begin
                lk_valid = 1'b1;
                lk_base  = i_desc_qual_addr;
                lk_len   = i_desc_qual_len;
            end
            8'd2: begin
                lk_valid = 1'b1;
                lk_base  = i_hs_mode ? i_desc_hscfg_addr : i_desc_fscfg_addr;
                lk_len   = i_hs_mode ? i_desc_hscfg_len  : i_desc_fscfg_len;
            end
            // Other-speed config reuses the opposite config, with its type byte rewritten
            8'd7: if (HSSUPPORT) begin
                lk_valid = 1'b1;
                lk_patch = 1'b1;
                lk_base  = i_hs_mode ? i_desc_fscfg_addr : i_desc_hscfg_addr;
                lk_len   = i_hs_mode ? i_desc_fscfg_len  : i_desc_hscfg_len;
            end
            8'd3: if (i_have_strings) begin
                case (index_q)
                    8'd0: begin
                        lk_valid = 1'b1;
                        lk_base  = i_desc_strlang_addr;
                        lk_len   = LW'(4);
                    end
                    8'd1: begin
                        lk_valid = 1'b1;
                        lk_base  = i_desc_strvendor_addr;
                        lk_len   = i_desc_strvendor_len;
                    end
                    8'd2: begin
                        lk_valid = 1'b1;
                        lk_base  = i_desc_strproduct_addr;
                        lk_len   = i_desc_strproduct_len;
                    end
                    8'd3: begin
                        lk_valid = 1'b1;
                        lk_base  = i_desc_strserial_addr;
                        lk_len   = i_desc_strserial_len;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Transfer sizing helpers
    always_comb begin
        lk_len16  = XW'(lk_len);
        lk_xfer   = (lk_len16 < wlen_q) ? lk_len16 : wlen_q;
        lk_zlp    = (lk_xfer < wlen_q) && (lk_xfer != '0) &&
                    ((lk_xfer % XW'(MAXPKT)) == '0);
        remaining = xfer_q - offset_q;
        off_next  = offset_q + XW'(pkt_len_q);
        last_byte = (cnt_q == pkt_len_q - LW'(1));
    end

    // Next-state and next-register logic
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        index_d     = index_q;
        wlen_d      = wlen_q;
        base_d      = base_q;
        xfer_d      = xfer_q;
        offset_d    = offset_q;
        pkt_len_d   = pkt_len_q;
        cnt_d       = cnt_q;
        zlp_pend_d  = zlp_pend_q;
        patch_d     = patch_q;
        raddr_d     = raddr_q;
        tx_valid_d  = tx_valid_q;
        req_ok_d    = 1'b0;
        req_stall_d = 1'b0;
        tx_zlp_d    = 1'b0;

        case (state_q)
            IDLE: if (i_req_valid) begin
                type_d  = i_desc_type;
                index_d = i_desc_index;
                wlen_d  = i_wlength;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                if (!lk_valid) begin
                    req_stall_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    req_ok_d   = 1'b1;
                    base_d     = lk_base;
                    xfer_d     = lk_xfer;
                    zlp_pend_d = lk_zlp;
                    patch_d    = lk_patch;
                    offset_d   = '0;
                    state_d    = (lk_xfer == '0) ? DONE : WAIT_IN;
                end
            end
            WAIT_IN: if (i_in_req) begin
                if (remaining != '0) begin
                    pkt_len_d  = (remaining > XW'(MAXPKT)) ? LW'(MAXPKT) : LW'(remaining);
                    raddr_d    = base_q + AW'(offset_q);
                    cnt_d      = '0;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end else if (zlp_pend_q) begin
                    tx_zlp_d   = 1'b1;
                    pkt_len_d  = '0;
                    zlp_pend_d = 1'b0;
                    state_d    = WAIT_HS;
                end
            end
            SEND: if (i_tx_ready) begin
                raddr_d = raddr_q + AW'(1);
                cnt_d   = cnt_q + LW'(1);
                if (last_byte) begin
                    tx_valid_d = 1'b0;
                    state_d    = WAIT_HS;
                end
            end
            WAIT_HS: begin
                if (i_in_ack) begin
                    offset_d = off_next;
                    state_d  = (off_next == xfer_q && !zlp_pend_q) ? DONE : WAIT_IN;
                end else if (i_in_retry) begin
                    // A lost ZLP has to be offered again
                    if (pkt_len_q == '0) zlp_pend_d = 1'b1;
                    state_d = WAIT_IN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (i_abort) begin
            state_d     = IDLE;
            req_ok_d    = 1'b0;
            req_stall_d = 1'b0;
            tx_zlp_d    = 1'b0;
            tx_valid_d  = 1'b0;
            raddr_d     = '0;
            offset_d    = '0;
            xfer_d      = '0;
            zlp_pend_d  = 1'b0;
            patch_d     = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            type_q      <= '0;
            index_q     <= '0;
            wlen_q      <= '0;
            base_q      <= '0;
            xfer_q      <= '0;
            offset_q    <= '0;
            pkt_len_q   <= '0;
            cnt_q       <= '0;
            zlp_pend_q  <= 1'b0;
            patch_q     <= 1'b0;
            raddr_q     <= '0;
            tx_valid_q  <= 1'b0;
            req_ok_q    <= 1'b0;
            req_stall_q <= 1'b0;
            tx_zlp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            index_q     <= index_d;
            wlen_q      <= wlen_d;
            base_q      <= base_d;
            xfer_q      <= xfer_d;
            offset_q    <= offset_d;
            pkt_len_q   <= pkt_len_d;
            cnt_q       <= cnt_d;
            zlp_pend_q  <= zlp_pend_d;
            patch_q     <= patch_d;
            raddr_q     <= raddr_d;
            tx_valid_q  <= tx_valid_d;
            req_ok_q    <= req_ok_d;
            req_stall_q <= req_stall_d;
            tx_zlp_q    <= tx_zlp_d;
        end
    end

    assign o_req_ok        = req_ok_q;
    assign o_req_stall     = req_stall_q;
    assign o_busy          = (state_q != IDLE);
    assign o_descrom_raddr = raddr_q;
    assign o_tx_valid      = tx_valid_q;
    assign o_tx_zlp        = tx_zlp_q;
    assign o_tx_last       = tx_valid_q && last_byte;
    // ROM read is asynchronous, so data follows the registered address
    assign o_tx_data       = !tx_valid_q ? 8'h00 :
                             (patch_q && (raddr_q - base_q) == AW'(1)) ? 8'h07 :
                             i_descrom_rdat;

endmodule

// File: tb/tb_usb_desc_ep0_streamer.sv
module tb_usb_desc_ep0_streamer;

    localparam int MAXA = 8;
    localparam int MAXB = 64;

    localparam logic [9:0] DEV_A  = 10'd100;
    localparam logic [9:0] QUAL_A = 10'd200;
    localparam logic [9:0] FS_A   = 10'd300;
    localparam logic [9:0] HS_A   = 10'd400;
    localparam logic [9:0] LANG_A = 10'd500;
    localparam logic [9:0] VEN_A  = 10'd520;
    localparam logic [9:0] PRO_A  = 10'd540;
    localparam logic [9:0] SER_A  = 10'd560;
    localparam logic [7:0] DEV_L  = 8'd18;
    localparam logic [7:0] QUAL_L = 8'd10;
    localparam logic [7:0] FS_L   = 8'd32;
    localparam logic [7:0] HS_L   = 8'd25;
    localparam logic [7:0] VEN_L  = 8'd12;
    localparam logic [7:0] PRO_L  = 8'd20;
    localparam logic [7:0] SER_L  = 8'd8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        i_abort, i_hs_mode, i_req_valid, i_have_strings;
    logic [7:0]  i_desc_type, i_desc_index;
    logic [15:0] i_wlength;
    logic        i_in_req, i_in_ack, i_in_retry;
    logic        i_tx_ready = 1'b1;

    logic        a_req_ok, a_req_stall, a_busy, a_tx_valid, a_tx_last, a_tx_zlp;
    logic [7:0]  a_tx_data, a_rdat;
    logic [9:0]  a_raddr;
    logic        b_req_ok, b_req_stall, b_busy, b_tx_valid, b_tx_last, b_tx_zlp;
    logic [7:0]  b_tx_data, b_rdat;
    logic [9:0]  b_raddr;

    logic [7:0]  rom [0:1023];
    assign a_rdat = rom[a_raddr];
    assign b_rdat = rom[b_raddr];

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 0;

    typedef struct {
        bit         zlp;
        logic [7:0] data;
        bit         last;
    } item_t;
    item_t sb[$];

    typedef struct {
        logic [7:0] t;
        logic [7:0] idx;
        bit         hs;
        bit         str;
        bit         ok_a;
        bit         ok_b;
    } vec_t;
    vec_t vt [12];

    always #5 CLK = ~CLK;

    usb_desc_ep0_streamer #(.MAXPKT(MAXA), .HSSUPPORT(1'b1)) dut_a (
        .CLK(CLK), .RESET(RESET), .i_abort(i_abort), .i_hs_mode(i_hs_mode),
        .i_req_valid(i_req_valid), .i_desc_type(i_desc_type), .i_desc_index(i_desc_index),
        .i_wlength(i_wlength), .o_req_ok(a_req_ok), .o_req_stall(a_req_stall), .o_busy(a_busy),
        .i_desc_dev_addr(DEV_A), .i_desc_dev_len(DEV_L),
        .i_desc_qual_addr(QUAL_A), .i_desc_qual_len(QUAL_L),
        .i_desc_fscfg_addr(FS_A), .i_desc_fscfg_len(FS_L),
        .i_desc_hscfg_addr(HS_A), .i_desc_hscfg_len(HS_L),
        .i_desc_strvendor_addr(VEN_A), .i_desc_strvendor_len(VEN_L),
        .i_desc_strproduct_addr(PRO_A), .i_desc_strproduct_len(PRO_L),
        .i_desc_strserial_addr(SER_A), .i_desc_strserial_len(SER_L),
        .i_desc_strlang_addr(LANG_A), .i_have_strings(i_have_strings),
        .o_descrom_raddr(a_raddr), .i_descrom_rdat(a_rdat), .i_in_req(i_in_req),
        .o_tx_valid(a_tx_valid), .o_tx_data(a_tx_data), .o_tx_last(a_tx_last),
        .i_tx_ready(i_tx_ready), .o_tx_zlp(a_tx_zlp), .i_in_ack(i_in_ack), .i_in_retry(i_in_retry)
    );

    usb_desc_ep0_streamer #(.MAXPKT(MAXB), .HSSUPPORT(1'b0)) dut_b (
        .CLK(CLK), .RESET(RESET), .i_abort(i_abort), .i_hs_mode(i_hs_mode),
        .i_req_valid(i_req_valid), .i_desc_type(i_desc_type), .i_desc_index(i_desc_index),
        .i_wlength(i_wlength), .o_req_ok(b_req_ok), .o_req_stall(b_req_stall), .o_busy(b_busy),
        .i_desc_dev_addr(DEV_A), .i_desc_dev_len(DEV_L),
        .i_desc_qual_addr(QUAL_A), .i_desc_qual_len(QUAL_L),
        .i_desc_fscfg_addr(FS_A), .i_desc_fscfg_len(FS_L),
        .i_desc_hscfg_addr(HS_A), .i_desc_hscfg_len(HS_L),
        .i_desc_strvendor_addr(VEN_A), .i_desc_strvendor_len(VEN_L),
        .i_desc_strproduct_addr(PRO_A), .i_desc_strproduct_len(PRO_L),
        .i_desc_strserial_addr(SER_A), .i_desc_strserial_len(SER_L),
        .i_desc_strlang_addr(LANG_A), .i_have_strings(i_have_strings),
        .o_descrom_raddr(b_raddr), .i_descrom_rdat(b_rdat), .i_in_req(i_in_req),
        .o_tx_valid(b_tx_valid), .o_tx_data(b_tx_data), .o_tx_last(b_tx_last),
        .i_tx_ready(i_tx_ready), .o_tx_zlp(b_tx_zlp), .i_in_ack(i_in_ack), .i_in_retry(i_in_retry)
    );

    // Sink readiness: always ready, random gaps, or stalled
    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0:       i_tx_ready = 1'b1;
            1:       i_tx_ready = ($urandom_range(0, 2) != 0);
            default: i_tx_ready = 1'b0;
        endcase
    end

    // Output monitor on dut_a, sampled mid-cycle
    item_t      mon_it;
    logic [7:0] prev_data;
    bit         prev_hold = 1'b0;
    always @(negedge CLK) begin
        if (!RESET) begin
            if (prev_hold) begin
                checks++;
                if (!(a_tx_valid === 1'b1 && a_tx_data === prev_data)) begin
                    failures++;
                    $display("FAIL tx_hold: got valid=%0b data=%02h, required valid=1 data=%02h",
                             a_tx_valid, a_tx_data, prev_data);
                end
            end
            if (a_tx_zlp) begin
                checks++;
                if (sb.size() == 0 || !sb[0].zlp) begin
                    failures++;
                    $display("FAIL tx_zlp: got unexpected zlp, required %0s",
                             sb.size() == 0 ? "nothing" : "a data byte");
                end
                if (sb.size() != 0) void'(sb.pop_front());
            end
            if (a_tx_valid && i_tx_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL tx_byte: got data=%02h with nothing expected", a_tx_data);
                end else begin
                    mon_it = sb.pop_front();
                    if (mon_it.zlp || a_tx_data !== mon_it.data || a_tx_last !== mon_it.last) begin
                        failures++;
                        $display("FAIL tx_byte: got data=%02h last=%0b, required zlp=%0b data=%02h last=%0b",
                                 a_tx_data, a_tx_last, mon_it.zlp, mon_it.data, mon_it.last);
                    end
                end
            end
            prev_hold = a_tx_valid && !i_tx_ready && !i_abort;
            prev_data = a_tx_data;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int base, input int idx, input bit patch);
        if (patch && idx == 1) return 8'h07;
        return rom[10'(base + idx)];
    endfunction

    task automatic do_abort();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_busy", 32'(a_busy), 32'd0);
    endtask

    task automatic request(input logic [7:0] t, input logic [7:0] idx, input logic [15:0] wl,
                           input bit ok_a, input bit ok_b, input string name);
        i_desc_type  = t;
        i_desc_index = idx;
        i_wlength    = wl;
        i_req_valid  = 1'b1;
        tick();
        i_req_valid  = 1'b0;
        chk({name, "_early"}, 32'({a_req_ok, a_req_stall}), 32'd0);
        tick();
        chk({name, "_verdict_a"}, 32'({a_req_ok, a_req_stall}), ok_a ? 32'd2 : 32'd1);
        chk({name, "_verdict_b"}, 32'({b_req_ok, b_req_stall}), ok_b ? 32'd2 : 32'd1);
        if (!ok_a) chk({name, "_idle_after_stall"}, 32'(a_busy), 32'd0);
    endtask

    // One IN packet of n bytes (n == 0 means a ZLP), drained through the scoreboard
    task automatic send_pkt(input int base, input int off, input int n, input bit patch);
        item_t it;
        int    cyc;
        for (int k = 0; k < n; k++) begin
            it.zlp  = 1'b0;
            it.data = exp_byte(base, off + k, patch);
            it.last = (k == n - 1);
            sb.push_back(it);
        end
        if (n == 0) begin
            it.zlp = 1'b1; it.data = 8'h00; it.last = 1'b0;
            sb.push_back(it);
        end
        i_in_req = 1'b1;
        tick();
        i_in_req = 1'b0;
        if (n == 0) chk("zlp_latency", 32'(a_tx_zlp), 32'd1);
        else        chk("first_byte_latency", 32'(a_tx_valid), 32'd1);
        cyc = 0;
        while (sb.size() != 0 && cyc < 400) begin
            tick();
            cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL pkt_timeout: got %0d items outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic handshake(input bit ack, input bit retry);
        i_in_ack   = ack;
        i_in_retry = retry;
        tick();
        i_in_ack   = 1'b0;
        i_in_retry = 1'b0;
    endtask

    // Reference transfer: packet split, optional retry / ack+retry, ZLP termination
    task automatic run_xfer(input int base, input int dlen, input int wlen, input bit patch,
                            input int retry_pkt, input int both_pkt);
        int xfer, off, pk, p;
        bit zlp;
        xfer = (dlen < wlen) ? dlen : wlen;
        zlp  = (xfer < wlen) && (xfer != 0) && (xfer % MAXA == 0);
        off  = 0;
        p    = 0;
        while (off < xfer) begin
            pk = xfer - off;
            if (pk > MAXA) pk = MAXA;
            send_pkt(base, off, pk, patch);
            if (p == retry_pkt) begin
                handshake(1'b0, 1'b1);
                send_pkt(base, off, pk, patch);
            end
            handshake(1'b1, p == both_pkt);
            off += pk;
            p++;
        end
        if (zlp) begin
            send_pkt(base, off, 0, patch);
            if (p == retry_pkt) begin
                handshake(1'b0, 1'b1);
                send_pkt(base, off, 0, patch);
            end
            handshake(1'b1, 1'b0);
        end
        chk("done_busy", 32'(a_busy), 32'd1);
        tick();
        chk("idle_busy", 32'(a_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 8'(i * 13 + (i >> 4));

        vt[0]  = '{8'd1,  8'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[1]  = '{8'd6,  8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{8'd7,  8'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{8'd2,  8'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[4]  = '{8'd3,  8'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[5]  = '{8'd3,  8'd3, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[6]  = '{8'd3,  8'd4, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{8'd3,  8'd5, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{8'd3,  8'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{8'd4,  8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{8'd0,  8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[11] = '{8'h21, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};

        RESET = 1'b1;
        i_abort = 1'b0; i_hs_mode = 1'b0; i_req_valid = 1'b0; i_have_strings = 1'b1;
        i_desc_type = '0; i_desc_index = '0; i_wlength = '0;
        i_in_req = 1'b0; i_in_ack = 1'b0; i_in_retry = 1'b0;
        repeat (3) tick();
        chk("reset_busy",   32'(a_busy), 32'd0);
        chk("reset_valid",  32'(a_tx_valid), 32'd0);
        chk("reset_raddr",  32'(a_raddr), 32'd0);
        chk("reset_verdict", 32'({a_req_ok, a_req_stall, a_tx_zlp}), 32'd0);
        RESET = 1'b0;
        tick();

        // Request verdict table on both configurations
        for (int i = 0; i < 12; i++) begin
            i_hs_mode      = vt[i].hs;
            i_have_strings = vt[i].str;
            request(vt[i].t, vt[i].idx, 16'd64, vt[i].ok_a, vt[i].ok_b, $sformatf("vec%0d", i));
            do_abort();
        end
        i_hs_mode = 1'b0;
        i_have_strings = 1'b1;

        // Language string: single short packet
        do_abort();
        request(8'd3, 8'd0, 16'd64, 1'b1, 1'b1, "lang");
        run_xfer(LANG_A, 4, 64, 1'b0, -1, -1);

        // Device descriptor, wLength FFFF, random backpressure: 8, 8, 2
        rdy_mode = 1;
        do_abort();
        request(8'd1, 8'd0, 16'hFFFF, 1'b1, 1'b1, "dev_bp");
        run_xfer(DEV_A, 18, 65535, 1'b0, -1, -1);

        // FS config, exact multiple of MAXPKT, short wLength: ZLP, retried once
        do_abort();
        request(8'd2, 8'd0, 16'd255, 1'b1, 1'b1, "fscfg_zlp");
        run_xfer(FS_A, 32, 255, 1'b0, 4, -1);

        // Truncated to wLength 9: 8 + 1, no ZLP
        do_abort();
        request(8'd2, 8'd0, 16'd9, 1'b1, 1'b1, "fscfg_trunc");
        run_xfer(FS_A, 32, 9, 1'b0, -1, -1);

        // Other-speed config in HS mode: fscfg bytes, byte 1 patched
        i_hs_mode = 1'b1;
        do_abort();
        request(8'd7, 8'd0, 16'd40, 1'b1, 1'b0, "othspd");
        run_xfer(FS_A, 32, 40, 1'b1, -1, -1);

        // Config in HS mode selects hscfg
        do_abort();
        request(8'd2, 8'd0, 16'd3, 1'b1, 1'b1, "hscfg");
        run_xfer(HS_A, 25, 3, 1'b0, -1, -1);
        i_hs_mode = 1'b0;

        // Retry of packet 0, then ack+retry together on packet 1 advances
        do_abort();
        request(8'd1, 8'd0, 16'd18, 1'b1, 1'b1, "retry");
        run_xfer(DEV_A, 18, 18, 1'b0, 0, 1);
        rdy_mode = 0;

        // wLength 0: verdict then straight to DONE
        do_abort();
        request(8'd1, 8'd0, 16'd0, 1'b1, 1'b1, "wlen0");
        run_xfer(DEV_A, 18, 0, 1'b0, -1, -1);

        // Serial string of exactly one packet followed by a ZLP
        do_abort();
        request(8'd3, 8'd3, 16'd255, 1'b1, 1'b1, "serial");
        run_xfer(SER_A, 8, 255, 1'b0, -1, -1);

        // Abort in the middle of SEND with the sink stalled
        rdy_mode = 2;
        do_abort();
        request(8'd1, 8'd0, 16'd64, 1'b1, 1'b1, "abort");
        i_in_req = 1'b1;
        tick();
        i_in_req = 1'b0;
        chk("abort_send_valid", 32'(a_tx_valid), 32'd1);
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_valid_drop", 32'(a_tx_valid), 32'd0);
        chk("abort_idle", 32'(a_busy), 32'd0);
        i_in_req = 1'b1;
        tick();
        i_in_req = 1'b0;
        chk("in_req_ignored_idle", 32'({a_tx_valid, a_tx_zlp}), 32'd0);
        rdy_mode = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
